// File: rtl/bus_datapath_seq.sv
// bus_datapath_seq: parametrised single-bus register/ALU datapath with an
// internal micro-sequencer. A three-register ALU instruction is accepted on a
// start pulse and then runs in three steps: load Y, compute Z, write back.
// A start/busy/done handshake reports progress, and err flags reserved opcodes.
module bus_datapath_seq #(
  parameter int WIDTH    = 32,
  parameter int NREGS    = 16,
  parameter int AW       = $clog2(NREGS),
  parameter int ZERO_REG = 1
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [AW-1:0]    ra,
  input  logic [AW-1:0]    rb,
  input  logic [AW-1:0]    rd,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data,
  output logic [WIDTH-1:0] hi_out,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SHL  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_ROL  = 4'd8;
  localparam logic [3:0] OP_ROR  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_NEG  = 4'd11;
  localparam logic [3:0] OP_NOT  = 4'd12;
  localparam logic [3:0] OP_MFHI = 4'd13;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TY   = 2'd1,
    S_TZ   = 2'd2,
    S_TWB  = 2'd3
  } state_t;

  // R0 reads as zero when it is hardwired.
  function automatic logic [WIDTH-1:0] f_gate(input logic [AW-1:0] addr,
                                               input logic [WIDTH-1:0] data);
    if ((ZERO_REG != 0) && (addr == {AW{1'b0}})) begin
      f_gate = {WIDTH{1'b0}};
    end else begin
      f_gate = data;
    end
  endfunction

  // Writes to a hardwired R0 are dropped.
  function automatic logic f_writable(input logic [AW-1:0] addr);
    f_writable = !((ZERO_REG != 0) && (addr == {AW{1'b0}}));
  endfunction

  logic [WIDTH-1:0]   r_regs [NREGS];
  state_t             r_state;
  logic [3:0]         r_op;
  logic [AW-1:0]      r_ra;
  logic [AW-1:0]      r_rb;
  logic [AW-1:0]      r_rd;
  logic [WIDTH-1:0]   r_y;
  logic [WIDTH-1:0]   r_zlo;
  logic [WIDTH-1:0]   r_zhi;
  logic               r_zc;
  logic [WIDTH-1:0]   r_hi;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic               r_flag_z;
  logic               r_flag_n;
  logic               r_flag_c;

  logic [WIDTH-1:0]   w_bus;
  logic [WIDTH-1:0]   w_lo;
  logic [WIDTH-1:0]   w_hi;
  logic               w_c;
  logic [SHW-1:0]     w_amt;
  logic [2*WIDTH-1:0] w_rot2;
  logic [2*WIDTH-1:0] w_y_ext;
  logic [2*WIDTH-1:0] w_b_ext;
  logic [2*WIDTH-1:0] w_prod;
  logic               w_reserved;

  assign w_reserved = (r_op[3:1] == 3'b111);
  assign w_amt      = w_bus[SHW-1:0];
  assign w_y_ext    = {{WIDTH{r_y[WIDTH-1]}}, r_y};
  assign w_b_ext    = {{WIDTH{w_bus[WIDTH-1]}}, w_bus};
  assign w_prod     = $signed(w_y_ext) * $signed(w_b_ext);

  assign dbg_data = f_gate(dbg_addr, r_regs[dbg_addr]);
  assign hi_out   = r_hi;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;
  assign flag_z   = r_flag_z;
  assign flag_n   = r_flag_n;
  assign flag_c   = r_flag_c;

  // Internal bus source: R[ra] in TY, R[rb] (or HI for MFHI) in TZ.
  always_comb begin
    w_bus = {WIDTH{1'b0}};
    case (r_state)
      S_TY: w_bus = f_gate(r_ra, r_regs[r_ra]);
      S_TZ: begin
        if (r_op == OP_MFHI) begin
          w_bus = r_hi;
        end else begin
          w_bus = f_gate(r_rb, r_regs[r_rb]);
        end
      end
      default: w_bus = {WIDTH{1'b0}};
    endcase
  end

  // ALU: Y op bus into {hi, lo} plus the carry/not-borrow used by the flags.
  always_comb begin
    w_lo   = {WIDTH{1'b0}};
    w_hi   = {WIDTH{1'b0}};
    w_c    = 1'b0;
    w_rot2 = {2*WIDTH{1'b0}};
    case (r_op)
      OP_ADD:  {w_c, w_lo} = {1'b0, r_y} + {1'b0, w_bus};
      OP_SUB: begin
        w_lo = r_y - w_bus;
        w_c  = (r_y >= w_bus);
      end
      OP_AND:  w_lo = r_y & w_bus;
      OP_OR:   w_lo = r_y | w_bus;
      OP_XOR:  w_lo = r_y ^ w_bus;
      OP_SHL:  w_lo = r_y << w_amt;
      OP_SHR:  w_lo = r_y >> w_amt;
      OP_SRA:  w_lo = $signed(r_y) >>> w_amt;
      OP_ROL: begin
        w_rot2 = {r_y, r_y} << w_amt;
        w_lo   = w_rot2[2*WIDTH-1:WIDTH];
      end
      OP_ROR: begin
        w_rot2 = {r_y, r_y} >> w_amt;
        w_lo   = w_rot2[WIDTH-1:0];
      end
      OP_MUL:  {w_hi, w_lo} = w_prod;
      OP_NEG:  w_lo = {WIDTH{1'b0}} - w_bus;
      OP_NOT:  w_lo = ~w_bus;
      OP_MFHI: w_lo = w_bus;
      default: w_lo = {WIDTH{1'b0}};
    endcase
  end

  // Micro-sequencer: instruction latch, Y/Z/HI, handshake and flags.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state  <= S_IDLE;
      r_op     <= 4'd0;
      r_ra     <= {AW{1'b0}};
      r_rb     <= {AW{1'b0}};
      r_rd     <= {AW{1'b0}};
      r_y      <= {WIDTH{1'b0}};
      r_zlo    <= {WIDTH{1'b0}};
      r_zhi    <= {WIDTH{1'b0}};
      r_zc     <= 1'b0;
      r_hi     <= {WIDTH{1'b0}};
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_flag_z <= 1'b0;
      r_flag_n <= 1'b0;
      r_flag_c <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          r_err  <= 1'b0;
          if (start) begin
            r_op    <= op;
            r_ra    <= ra;
            r_rb    <= rb;
            r_rd    <= rd;
            r_busy  <= 1'b1;
            r_state <= S_TY;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_TY: begin
          r_y     <= w_bus;
          r_state <= S_TZ;
        end
        S_TZ: begin
          r_zlo   <= w_lo;
          r_zhi   <= w_hi;
          r_zc    <= w_c;
          r_state <= S_TWB;
        end
        S_TWB: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_err   <= w_reserved;
          r_state <= S_IDLE;
          if (!w_reserved) begin
            if (r_op == OP_MUL) begin
              r_hi     <= r_zhi;
              r_flag_n <= r_zhi[WIDTH-1];
            end else begin
              r_flag_n <= r_zlo[WIDTH-1];
            end
            r_flag_z <= ({r_zhi, r_zlo} == {2*WIDTH{1'b0}});
            r_flag_c <= r_zc;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Register file: external writes in IDLE, ALU writeback in TWB.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= {WIDTH{1'b0}};
      end
    end else if ((r_state == S_IDLE) && wr_en && f_writable(wr_addr)) begin
      r_regs[wr_addr] <= wr_data;
    end else if ((r_state == S_TWB) && !w_reserved && f_writable(r_rd)) begin
      r_regs[r_rd] <= r_zlo;
    end
  end

endmodule

// File: tb/tb_bus_datapath_seq.sv
// Self-checking bench for bus_datapath_seq: directed scenarios plus random
// instructions compared against a behavioural model of the instruction set.
module tb_bus_datapath_seq;
  localparam int W = 32;
  localparam int N = 16;

  logic         clock = 1'b0;
  logic         clear = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   op = 4'd0;
  logic [3:0]   ra = 4'd0, rb = 4'd0, rd = 4'd0;
  logic         wr_en = 1'b0;
  logic [3:0]   wr_addr = 4'd0;
  logic [W-1:0] wr_data = 32'd0;
  logic [3:0]   dbg_addr = 4'd0;
  logic [W-1:0] dbg_data, hi_out;
  logic         busy, done, err, flag_z, flag_n, flag_c;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] m_regs [N];
  logic [W-1:0] m_hi;
  logic         m_z, m_n, m_c;

  bus_datapath_seq #(.WIDTH(W), .NREGS(N), .ZERO_REG(1)) dut (
    .clock(clock), .clear(clear), .start(start), .op(op),
    .ra(ra), .rb(rb), .rd(rd),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .hi_out(hi_out),
    .busy(busy), .done(done), .err(err),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_regs[i] = 32'd0;
    m_hi = 32'd0; m_z = 1'b0; m_n = 1'b0; m_c = 1'b0;
  endtask

  function automatic logic [W-1:0] m_rd(input logic [3:0] a);
    return (a == 4'd0) ? 32'd0 : m_regs[a];
  endfunction

  // Instruction-set model: plain arithmetic, bit-at-a-time shifts/rotates.
  task automatic model_exec(input logic [3:0] o, input logic [3:0] a_i, b_i, d_i);
    logic [W-1:0] a, b, res;
    logic [W:0]   s;
    longint       sa, sb, p;
    int           amt;
    a = m_rd(a_i);
    b = (o == 4'd13) ? m_hi : m_rd(b_i);
    amt = int'(b[4:0]);
    res = 32'd0; p = 64'sd0;
    if (o >= 4'd14) return;
    m_c = 1'b0;
    case (o)
      4'd0: begin s = {1'b0, a} + {1'b0, b}; res = s[W-1:0]; m_c = s[W]; end
      4'd1: begin res = a - b; m_c = (a >= b); end
      4'd2: res = a & b;
      4'd3: res = a | b;
      4'd4: res = a ^ b;
      4'd5: begin res = a; repeat (amt) res = {res[W-2:0], 1'b0}; end
      4'd6: begin res = a; repeat (amt) res = {1'b0, res[W-1:1]}; end
      4'd7: begin res = a; repeat (amt) res = {res[W-1], res[W-1:1]}; end
      4'd8: begin res = a; repeat (amt) res = {res[W-2:0], res[W-1]}; end
      4'd9: begin res = a; repeat (amt) res = {res[0], res[W-1:1]}; end
      4'd10: begin
        sa = $signed(a); sb = $signed(b); p = sa * sb;
        res = p[W-1:0]; m_hi = p[63:32];
      end
      4'd11: res = 32'd0 - b;
      4'd12: res = ~b;
      4'd13: res = b;
      default: res = 32'd0;
    endcase
    if (o == 4'd10) begin m_z = (p == 64'sd0); m_n = p[63]; end
    else begin m_z = (res == 32'd0); m_n = res[W-1]; end
    if (d_i != 4'd0) m_regs[d_i] = res;
  endtask

  task automatic peek(input logic [3:0] a, output logic [W-1:0] v);
    dbg_addr = a; #1; v = dbg_data;
  endtask

  task automatic wr(input logic [3:0] a, input logic [W-1:0] v);
    @(negedge clock);
    wr_en = 1'b1; wr_addr = a; wr_data = v;
    @(negedge clock);
    wr_en = 1'b0;
    if (a != 4'd0) m_regs[a] = v;
  endtask

  // Issues one instruction; returns edges from accept to done (-1 on timeout),
  // err at done, busy one cycle after accept, busy in the done cycle.
  task automatic issue(input logic [3:0] o, a, b, d, output int lat,
                       output logic e, output logic b_fl, output logic b_dn);
    @(negedge clock);
    op = o; ra = a; rb = b; rd = d; start = 1'b1;
    @(negedge clock);
    start = 1'b0; b_fl = busy; lat = -1; e = 1'b0; b_dn = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) @(negedge clock);
      else @(negedge clock);
      if (done === 1'b1) begin lat = k; e = err; b_dn = busy; break; end
    end
    model_exec(o, a, b, d);
  endtask

  task automatic test_reset();
    logic [W-1:0] v;
    int ndone;
    repeat (3) @(negedge clock);
    n_checks++;
    if ({busy, done, err, flag_z, flag_n, flag_c} !== 6'b0 || hi_out !== 32'd0) begin
      $display("FAIL reset_outputs got %b hi=%h want 000000 hi=0",
               {busy, done, err, flag_z, flag_n, flag_c}, hi_out);
      n_fail++;
    end
    clear = 1'b1;
    model_reset();
    wr(4'd1, 32'd3); wr(4'd2, 32'd4);
    @(negedge clock);
    op = 4'd0; ra = 4'd1; rb = 4'd2; rd = 4'd3; start = 1'b1;
    @(negedge clock); start = 1'b0;   // now in TY
    @(negedge clock);                 // now in TZ
    clear = 1'b0; #1;
    n_checks++;
    if (busy !== 1'b0) begin $display("FAIL midreset_busy got %b want 0", busy); n_fail++; end
    #1 clear = 1'b1;
    ndone = 0;
    repeat (6) begin @(negedge clock); if (done === 1'b1) ndone++; end
    n_checks++;
    if (ndone != 0) begin $display("FAIL midreset_done got %0d pulses want 0", ndone); n_fail++; end
    model_reset();
    for (int i = 0; i < N; i++) begin
      peek(4'(i), v);
      n_checks++;
      if (v !== 32'd0) begin $display("FAIL midreset_reg%0d got %h want 0", i, v); n_fail++; end
    end
    n_checks++;
    if ({flag_z, flag_n, flag_c} !== 3'b000) begin
      $display("FAIL midreset_flags got %b want 000", {flag_z, flag_n, flag_c}); n_fail++;
    end
  endtask

  task automatic test_add();
    int lat; logic e, bf, bd; logic [W-1:0] v;
    wr(4'd1, 32'd7); wr(4'd2, 32'd5);
    issue(4'd0, 4'd1, 4'd2, 4'd3, lat, e, bf, bd);
    n_checks++;
    if (lat != 3 || e !== 1'b0) begin $display("FAIL add_latency got lat=%0d err=%b want 3/0", lat, e); n_fail++; end
    n_checks++;
    if (bf !== 1'b1 || bd !== 1'b0) begin $display("FAIL add_busy got flight=%b done=%b want 1/0", bf, bd); n_fail++; end
    peek(4'd3, v);
    n_checks++;
    if (v !== 32'd12) begin $display("FAIL add_result got %h want 0000000c", v); n_fail++; end
    n_checks++;
    if ({flag_z, flag_n, flag_c} !== 3'b000) begin $display("FAIL add_flags got %b want 000", {flag_z, flag_n, flag_c}); n_fail++; end
  endtask

  task automatic test_sub_carry();
    int lat; logic e, bf, bd; logic [W-1:0] v;
    wr(4'd1, 32'd5); wr(4'd2, 32'd7);
    issue(4'd1, 4'd1, 4'd2, 4'd4, lat, e, bf, bd);
    peek(4'd4, v);
    n_checks++;
    if (v !== 32'hFFFF_FFFE || lat != 3) begin $display("FAIL sub_result got %h lat=%0d want fffffffe/3", v, lat); n_fail++; end
    n_checks++;
    if ({flag_z, flag_n, flag_c} !== 3'b010) begin $display("FAIL sub_flags got %b want 010", {flag_z, flag_n, flag_c}); n_fail++; end
    wr(4'd1, 32'hFFFF_FFFF); wr(4'd2, 32'd1);
    issue(4'd0, 4'd1, 4'd2, 4'd8, lat, e, bf, bd);
    peek(4'd8, v);
    n_checks++;
    if (v !== 32'd0) begin $display("FAIL addwrap_result got %h want 00000000", v); n_fail++; end
    n_checks++;
    if ({flag_z, flag_n, flag_c} !== 3'b101) begin $display("FAIL addwrap_flags got %b want 101", {flag_z, flag_n, flag_c}); n_fail++; end
  endtask

  task automatic test_mul_mfhi();
    int lat; logic e, bf, bd; logic [W-1:0] v;
    wr(4'd1, 32'h0001_0000); wr(4'd2, 32'h0001_0000);
    issue(4'd10, 4'd1, 4'd2, 4'd5, lat, e, bf, bd);
    peek(4'd5, v);
    n_checks++;
    if (v !== 32'd0 || hi_out !== 32'd1) begin $display("FAIL mul_result got lo=%h hi=%h want 0/1", v, hi_out); n_fail++; end
    n_checks++;
    if ({flag_z, flag_n, flag_c} !== 3'b000) begin $display("FAIL mul_flags got %b want 000", {flag_z, flag_n, flag_c}); n_fail++; end
    issue(4'd13, 4'd0, 4'd0, 4'd6, lat, e, bf, bd);
    peek(4'd6, v);
    n_checks++;
    if (v !== 32'd1) begin $display("FAIL mfhi_result got %h want 00000001", v); n_fail++; end
    wr(4'd1, 32'hFFFF_FFFE); wr(4'd2, 32'd3);
    issue(4'd10, 4'd1, 4'd2, 4'd5, lat, e, bf, bd);
    peek(4'd5, v);
    n_checks++;
    if (v !== 32'hFFFF_FFFA || hi_out !== 32'hFFFF_FFFF || flag_n !== 1'b1) begin
      $display("FAIL mulneg_result got lo=%h hi=%h n=%b want fffffffa/ffffffff/1", v, hi_out, flag_n); n_fail++;
    end
  endtask

  task automatic test_zero_reg();
    int lat; logic e, bf, bd; logic [W-1:0] v;
    wr(4'd0, 32'h0000_00FF);
    peek(4'd0, v);
    n_checks++;
    if (v !== 32'd0) begin $display("FAIL r0_write got %h want 0", v); n_fail++; end
    wr(4'd1, 32'd9);
    issue(4'd0, 4'd0, 4'd1, 4'd7, lat, e, bf, bd);
    peek(4'd7, v);
    n_checks++;
    if (v !== 32'd9) begin $display("FAIL r0_source got %h want 00000009", v); n_fail++; end
    issue(4'd0, 4'd1, 4'd1, 4'd0, lat, e, bf, bd);
    peek(4'd0, v);
    n_checks++;
    if (lat != 3 || v !== 32'd0) begin $display("FAIL r0_dest got lat=%0d r0=%h want 3/0", lat, v); n_fail++; end
  endtask

  task automatic test_reserved();
    int lat; logic e, bf, bd; logic [W-1:0] v; logic [2:0] fl; logic [W-1:0] h;
    for (int o = 14; o <= 15; o++) begin
      fl = {flag_z, flag_n, flag_c}; h = hi_out;
      issue(4'(o), 4'd1, 4'd2, 4'd3, lat, e, bf, bd);
      n_checks++;
      if (lat != 3 || e !== 1'b1) begin $display("FAIL reserved%0d_err got lat=%0d err=%b want 3/1", o, lat, e); n_fail++; end
      peek(4'd3, v);
      n_checks++;
      if (v !== m_regs[3] || {flag_z, flag_n, flag_c} !== fl || hi_out !== h) begin
        $display("FAIL reserved%0d_state got r3=%h fl=%b hi=%h want %h/%b/%h", o, v, {flag_z, flag_n, flag_c}, hi_out, m_regs[3], fl, h);
        n_fail++;
      end
    end
  endtask

  task automatic test_start_while_busy();
    int ndone, first; logic [W-1:0] v9, v10, v11;
    wr(4'd1, 32'd10); wr(4'd2, 32'd20);
    @(negedge clock);
    op = 4'd0; ra = 4'd1; rb = 4'd2; rd = 4'd9; start = 1'b1;
    @(negedge clock);                      // TY
    op = 4'd4; rd = 4'd10; start = 1'b1;
    ndone = 0; first = -1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      start = 1'b0;
      if (k == 1) begin wr_en = 1'b1; wr_addr = 4'd11; wr_data = 32'hDEAD; end
      else wr_en = 1'b0;
      if (done === 1'b1) begin ndone++; if (first < 0) first = k; end
    end
    model_exec(4'd0, 4'd1, 4'd2, 4'd9);
    n_checks++;
    if (ndone != 1 || first != 3) begin $display("FAIL busy_start got dones=%0d at=%0d want 1/3", ndone, first); n_fail++; end
    peek(4'd9, v9); peek(4'd10, v10); peek(4'd11, v11);
    n_checks++;
    if (v9 !== 32'd30 || v10 !== m_regs[10] || v11 !== m_regs[11]) begin
      $display("FAIL busy_state got r9=%h r10=%h r11=%h want 0000001e/%h/%h", v9, v10, v11, m_regs[10], m_regs[11]);
      n_fail++;
    end
  endtask

  task automatic test_wr_start_same_edge();
    int first; logic [W-1:0] v;
    @(negedge clock);
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = 32'h11;
    op = 4'd0; ra = 4'd1; rb = 4'd1; rd = 4'd12; start = 1'b1;
    @(negedge clock);
    wr_en = 1'b0; start = 1'b0; first = -1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (done === 1'b1) begin first = k; break; end
    end
    m_regs[1] = 32'h11;
    model_exec(4'd0, 4'd1, 4'd1, 4'd12);
    peek(4'd12, v);
    n_checks++;
    if (v !== 32'h22 || first != 3) begin $display("FAIL wr_start got %h at=%0d want 00000022/3", v, first); n_fail++; end
  endtask

  task automatic test_ror();
    int lat; logic e, bf, bd; logic [W-1:0] v;
    wr(4'd1, 32'd1); wr(4'd2, 32'd33);
    issue(4'd9, 4'd1, 4'd2, 4'd13, lat, e, bf, bd);
    peek(4'd13, v);
    n_checks++;
    if (v !== 32'h8000_0000 || {flag_z, flag_n, flag_c} !== 3'b010) begin
      $display("FAIL ror_result got %h fl=%b want 80000000/010", v, {flag_z, flag_n, flag_c}); n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic e, bf, bd; logic [W-1:0] v;
    wr(4'd1, 32'd100); wr(4'd2, 32'd23);
    issue(4'd0, 4'd1, 4'd2, 4'd3, lat, e, bf, bd);
    n_checks++;
    if (lat != 3) begin $display("FAIL b2b_first got lat=%0d want 3", lat); n_fail++; end
    issue(4'd1, 4'd3, 4'd2, 4'd3, lat, e, bf, bd);
    n_checks++;
    if (lat != 3) begin $display("FAIL b2b_second got lat=%0d want 3", lat); n_fail++; end
    issue(4'd5, 4'd3, 4'd2, 4'd4, lat, e, bf, bd);
    peek(4'd4, v);
    n_checks++;
    if (lat != 3 || v !== m_regs[4]) begin $display("FAIL b2b_third got lat=%0d r4=%h want 3/%h", lat, v, m_regs[4]); n_fail++; end
  endtask

  task automatic test_random();
    int lat; logic e, bf, bd; logic [W-1:0] v;
    logic [3:0] o, a, b, d;
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 2) == 0) wr(4'($urandom_range(0, 15)), $urandom);
      o = 4'($urandom_range(0, 15)); a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15)); d = 4'($urandom_range(0, 15));
      issue(o, a, b, d, lat, e, bf, bd);
      n_checks++;
      if (lat != 3 || e !== (o >= 4'd14)) begin
        $display("FAIL rnd%0d_handshake op=%0d got lat=%0d err=%b want 3/%b", it, o, lat, e, (o >= 4'd14)); n_fail++;
      end
      peek(d, v);
      n_checks++;
      if (v !== m_rd(d) || hi_out !== m_hi || {flag_z, flag_n, flag_c} !== {m_z, m_n, m_c}) begin
        $display("FAIL rnd%0d_result op=%0d got rd=%h hi=%h fl=%b want %h/%h/%b",
                 it, o, v, hi_out, {flag_z, flag_n, flag_c}, m_rd(d), m_hi, {m_z, m_n, m_c});
        n_fail++;
      end
    end
    for (int i = 0; i < N; i++) begin
      peek(4'(i), v);
      n_checks++;
      if (v !== m_rd(4'(i))) begin $display("FAIL rnd_regfile%0d got %h want %h", i, v, m_rd(4'(i))); n_fail++; end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_add();
    test_sub_carry();
    test_mul_mfhi();
    test_zero_reg();
    test_reserved();
    test_start_while_busy();
    test_wr_start_same_edge();
    test_ror();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
